// File: rtl/beamform_pkg.sv
// Shared sizing and bus-slicing helpers for the complex beamforming MAC.
package beamform_pkg;

  // Lossless output width: full product, one bit for the complex add, log2(N) for the tree.
  function automatic int unsigned y_width(input int unsigned w, input int unsigned n);
    return 2 * w + 1 + 32'($clog2(n));
  endfunction

  // Weight address width, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // LSB position of lane k in a packed bus of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/cplx_mul_stage.sv
// Single-channel complex multiply: S1 registers the four real products,
// S2 combines them into w or conj(w) form using the pipelined conj tag.
module cplx_mul_stage #(
  parameter int unsigned WORD_LENGTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic signed [WORD_LENGTH-1:0]  x_i,
  input  logic signed [WORD_LENGTH-1:0]  x_q,
  input  logic signed [WORD_LENGTH-1:0]  w_i,
  input  logic signed [WORD_LENGTH-1:0]  w_q,
  input  logic                           conj_in,
  output logic signed [2*WORD_LENGTH:0]  p_i,
  output logic signed [2*WORD_LENGTH:0]  p_q
);

  localparam int unsigned PW = 2 * WORD_LENGTH;
  localparam int unsigned SW = 2 * WORD_LENGTH + 1;

  logic signed [PW-1:0] m_ii, m_qq, m_iq, m_qi;
  logic                 conj_s1;

  // S1: raw real products, conj tag travels alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ii    <= '0;
      m_qq    <= '0;
      m_iq    <= '0;
      m_qi    <= '0;
      conj_s1 <= 1'b0;
    end else if (en) begin
      m_ii    <= PW'(x_i) * PW'(w_i);
      m_qq    <= PW'(x_q) * PW'(w_q);
      m_iq    <= PW'(x_i) * PW'(w_q);
      m_qi    <= PW'(x_q) * PW'(w_i);
      conj_s1 <= conj_in;
    end
  end

  // S2: complex recombination, sign-extended one bit so the add cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_i <= '0;
      p_q <= '0;
    end else if (en) begin
      if (conj_s1) begin
        p_i <= SW'(m_ii) + SW'(m_qq);
        p_q <= SW'(m_qi) - SW'(m_iq);
      end else begin
        p_i <= SW'(m_ii) - SW'(m_qq);
        p_q <= SW'(m_iq) + SW'(m_qi);
      end
    end
  end

endmodule

// File: rtl/complex_beamform_mac.sv
// Pipelined N-channel complex weighted sum with valid/ready backpressure and
// double-buffered steering weights (shadow written at runtime, active used by data).
module complex_beamform_mac
  import beamform_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned WORD_LENGTH   = 12,
  parameter int unsigned Y_WORD_LENGTH = y_width(WORD_LENGTH, N_CH),
  parameter int unsigned ADDR_W        = addr_width(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH*WORD_LENGTH-1:0]   x_I,
  input  logic [N_CH*WORD_LENGTH-1:0]   x_Q,
  input  logic                          w_we,
  input  logic [ADDR_W-1:0]             w_addr,
  input  logic [WORD_LENGTH-1:0]        w_I,
  input  logic [WORD_LENGTH-1:0]        w_Q,
  input  logic                          w_commit,
  input  logic                          conj_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Y_WORD_LENGTH-1:0]      y_I,
  output logic [Y_WORD_LENGTH-1:0]      y_Q
);

  localparam int unsigned PW  = 2 * WORD_LENGTH + 1;
  localparam int unsigned LVL = $clog2(N_CH);
  localparam int unsigned LAT = 3 + LVL;

  logic                          stall;
  logic [LAT-1:0]                vld;
  logic signed [WORD_LENGTH-1:0] shadow_i [N_CH];
  logic signed [WORD_LENGTH-1:0] shadow_q [N_CH];
  logic signed [WORD_LENGTH-1:0] shadow_i_nxt [N_CH];
  logic signed [WORD_LENGTH-1:0] shadow_q_nxt [N_CH];
  logic signed [WORD_LENGTH-1:0] active_i [N_CH];
  logic signed [WORD_LENGTH-1:0] active_q [N_CH];
  logic signed [PW-1:0]          prod_i [N_CH];
  logic signed [PW-1:0]          prod_q [N_CH];
  logic signed [Y_WORD_LENGTH-1:0] leaf_i [N_CH];
  logic signed [Y_WORD_LENGTH-1:0] leaf_q [N_CH];
  logic signed [Y_WORD_LENGTH-1:0] sum_i  [N_CH-1];
  logic signed [Y_WORD_LENGTH-1:0] sum_q  [N_CH-1];
  logic signed [Y_WORD_LENGTH-1:0] node_i [N_CH-1];
  logic signed [Y_WORD_LENGTH-1:0] node_q [N_CH-1];

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld[LAT-1];

  // Shadow bank after this cycle's write, so a same-cycle commit sees the new value.
  always_comb begin
    shadow_i_nxt = shadow_i;
    shadow_q_nxt = shadow_q;
    if (w_we && (32'(w_addr) < N_CH)) begin
      shadow_i_nxt[w_addr] = w_I;
      shadow_q_nxt[w_addr] = w_Q;
    end
  end

  // Weight banks update independently of pipeline stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        shadow_i[k] <= '0;
        shadow_q[k] <= '0;
        active_i[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      shadow_i <= shadow_i_nxt;
      shadow_q <= shadow_q_nxt;
      if (w_commit) begin
        active_i <= shadow_i_nxt;
        active_q <= shadow_q_nxt;
      end
    end
  end

  // Valid shift chain; bubbles advance like data, everything freezes on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (!stall) begin
      vld <= {vld[LAT-2:0], in_valid};
    end
  end

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    cplx_mul_stage #(.WORD_LENGTH(WORD_LENGTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .en      (!stall),
      .x_i     (x_I[lane_lsb(k, WORD_LENGTH) +: WORD_LENGTH]),
      .x_q     (x_Q[lane_lsb(k, WORD_LENGTH) +: WORD_LENGTH]),
      .w_i     (active_i[k]),
      .w_q     (active_q[k]),
      .conj_in (conj_en),
      .p_i     (prod_i[k]),
      .p_q     (prod_q[k])
    );
    assign leaf_i[k] = Y_WORD_LENGTH'(prod_i[k]);
    assign leaf_q[k] = Y_WORD_LENGTH'(prod_q[k]);
  end

  // Heap-indexed adder tree: node n (1-based) sums children 2n and 2n+1; leaves are N..2N-1.
  for (genvar n = 1; n < int'(N_CH); n++) begin : g_node
    if (2 * n >= int'(N_CH)) begin : g_leaf
      assign sum_i[n-1] = leaf_i[2*n-N_CH] + leaf_i[2*n+1-N_CH];
      assign sum_q[n-1] = leaf_q[2*n-N_CH] + leaf_q[2*n+1-N_CH];
    end else begin : g_inner
      assign sum_i[n-1] = node_i[2*n-1] + node_i[2*n];
      assign sum_q[n-1] = node_q[2*n-1] + node_q[2*n];
    end
  end

  // Register every tree level in lock-step with the valid chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < int'(N_CH) - 1; n++) begin
        node_i[n] <= '0;
        node_q[n] <= '0;
      end
    end else if (!stall) begin
      node_i <= sum_i;
      node_q <= sum_q;
    end
  end

  // Output register: holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_I <= '0;
      y_Q <= '0;
    end else if (!stall) begin
      y_I <= node_i[0];
      y_Q <= node_q[0];
    end
  end

endmodule

// File: tb/tb_complex_beamform_mac.sv
// Scoreboard bench for complex_beamform_mac (N_CH=4, WORD_LENGTH=12).
module tb_complex_beamform_mac;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int YW = 2 * W + 1 + 2;
  localparam int AW = 2;

  typedef int vec_t [N];
  typedef struct {
    longint yi;
    longint yq;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] x_I, x_Q;
  logic           w_we;
  logic [AW-1:0]  w_addr;
  logic [W-1:0]   w_I, w_Q;
  logic           w_commit;
  logic           conj_en;
  logic           out_valid;
  logic           out_ready;
  logic [YW-1:0]  y_I, y_Q;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];
  int   sh_i [N], sh_q [N], ac_i [N], ac_q [N];
  logic          prev_stall = 1'b0;
  logic [YW-1:0] held_i, held_q;

  complex_beamform_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_I(x_I), .x_Q(x_Q), .w_we(w_we), .w_addr(w_addr), .w_I(w_I), .w_Q(w_Q),
    .w_commit(w_commit), .conj_en(conj_en), .out_valid(out_valid),
    .out_ready(out_ready), .y_I(y_I), .y_Q(y_Q)
  );

  always #5 clk = ~clk;

  // Reference complex weighted sum using the bench's own active-bank model.
  function automatic exp_t model(input vec_t xi, input vec_t xq, input bit cj);
    exp_t e;
    e.yi = 0;
    e.yq = 0;
    for (int k = 0; k < N; k++) begin
      if (cj) begin
        e.yi += longint'(xi[k]) * ac_i[k] + longint'(xq[k]) * ac_q[k];
        e.yq += longint'(xq[k]) * ac_i[k] - longint'(xi[k]) * ac_q[k];
      end else begin
        e.yi += longint'(xi[k]) * ac_i[k] - longint'(xq[k]) * ac_q[k];
        e.yq += longint'(xi[k]) * ac_q[k] + longint'(xq[k]) * ac_i[k];
      end
    end
    return e;
  endfunction

  // Output monitor: scoreboard pops, stall hold and in_ready checks.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (y_I !== held_i || y_Q !== held_q) begin
          failures++;
          $display("FAIL stall_hold: y=(%0d,%0d) held=(%0d,%0d)", $signed(y_I), $signed(y_Q),
                   $signed(held_i), $signed(held_q));
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_stall: in_ready=%b expected 0", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: y=(%0d,%0d) with empty scoreboard",
                   $signed(y_I), $signed(y_Q));
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (longint'($signed(y_I)) !== e.yi || longint'($signed(y_Q)) !== e.yq) begin
            failures++;
            $display("FAIL result: y=(%0d,%0d) expected (%0d,%0d)", $signed(y_I), $signed(y_Q),
                     e.yi, e.yq);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_i = y_I;
      held_q = y_Q;
    end
  end

  task automatic send(input vec_t xi, input vec_t xq, input bit cj);
    bit acc = 1'b0;
    int n = 0;
    for (int k = 0; k < N; k++) begin
      x_I[k*W +: W] = W'(xi[k]);
      x_Q[k*W +: W] = W'(xq[k]);
    end
    conj_en  = cj;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      if (acc) sb.push_back(model(xi, xq, cj));
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic write_w(input int addr, input int wi, input int wq, input bit cm);
    w_we     = 1'b1;
    w_addr   = AW'(addr);
    w_I      = W'(wi);
    w_Q      = W'(wq);
    w_commit = cm;
    @(posedge clk);
    #1;
    w_we     = 1'b0;
    w_commit = 1'b0;
    sh_i[addr] = wi;
    sh_q[addr] = wq;
    if (cm) begin
      ac_i = sh_i;
      ac_q = sh_q;
    end
  endtask

  task automatic write_all(input int wi, input int wq);
    for (int k = 0; k < N; k++) write_w(k, wi, wq, k == N - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still outstanding", sb.size());
    end
  endtask

  task automatic rand_vec(output vec_t v);
    for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < N; k++) begin
      sh_i[k] = 0; sh_q[k] = 0; ac_i[k] = 0; ac_q[k] = 0;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y_I !== '0 || y_Q !== '0) begin
      failures++;
      $display("FAIL reset_y: got (%0d,%0d) expected (0,0)", $signed(y_I), $signed(y_Q));
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_latency();
    vec_t xi, xq;
    int n;
    write_all(1, 0);
    for (int k = 0; k < N; k++) begin
      xi[k] = k + 1;
      xq[k] = -(k + 1);
    end
    checks++;
    if (model(xi, xq, 1'b0).yi != 10 || model(xi, xq, 1'b0).yq != -10) begin
      failures++;
      $display("FAIL latency_model: expected (10,-10)");
    end
    send(xi, xq, 1'b0);
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL latency: out_valid after %0d edges expected 5", n);
    end
    wait_drain();
  endtask

  task automatic test_conj();
    vec_t xi, xq;
    exp_t e0, e1;
    write_all(3, 4);
    for (int k = 0; k < N; k++) begin
      xi[k] = 1;
      xq[k] = 2;
    end
    e0 = model(xi, xq, 1'b0);
    e1 = model(xi, xq, 1'b1);
    checks++;
    if (e0.yi != -20 || e0.yq != 40 || e1.yi != 44 || e1.yq != 8) begin
      failures++;
      $display("FAIL conj_model: got (%0d,%0d)/(%0d,%0d) expected (-20,40)/(44,8)",
               e0.yi, e0.yq, e1.yi, e1.yq);
    end
    send(xi, xq, 1'b0);
    send(xi, xq, 1'b1);
    wait_drain();
  endtask

  task automatic test_extreme();
    vec_t xi, xq;
    write_all(-2048, -2048);
    for (int k = 0; k < N; k++) begin
      xi[k] = -2048;
      xq[k] = -2048;
    end
    checks++;
    if (model(xi, xq, 1'b0).yi != 0 || model(xi, xq, 1'b0).yq != 33554432) begin
      failures++;
      $display("FAIL extreme_model: expected (0,33554432)");
    end
    send(xi, xq, 1'b0);
    send(xi, xq, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    write_all(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    fork
      begin
        vec_t xi, xq;
        for (int i = 0; i < 20; i++) begin
          rand_vec(xi);
          rand_vec(xq);
          send(xi, xq, 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_commit_inflight();
    vec_t xi, xq;
    int bi [N], bq [N];
    for (int k = 0; k < N; k++) begin
      bi[k] = int'($urandom_range(0, 4095)) - 2048;
      bq[k] = int'($urandom_range(0, 4095)) - 2048;
    end
    for (int k = 0; k < N - 1; k++) write_w(k, bi[k], bq[k], 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_vec(xi);
      rand_vec(xq);
      send(xi, xq, 1'b0);
    end
    write_w(N - 1, bi[N-1], bq[N-1], 1'b1);
    rand_vec(xi);
    rand_vec(xq);
    send(xi, xq, 1'b0);
    send(xi, xq, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    vec_t xi, xq;
    for (int i = 0; i < 4; i++) begin
      rand_vec(xi);
      rand_vec(xq);
      send(xi, xq, 1'b0);
    end
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < N; k++) begin
      sh_i[k] = 0; sh_q[k] = 0; ac_i[k] = 0; ac_q[k] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || y_I !== '0 || y_Q !== '0) begin
      failures++;
      $display("FAIL midflight_reset: out_valid=%b y=(%0d,%0d) expected 0,(0,0)",
               out_valid, $signed(y_I), $signed(y_Q));
    end
    repeat (10) begin @(posedge clk); #1; end
    rand_vec(xi);
    rand_vec(xq);
    xi[0] = 1000;
    send(xi, xq, 1'b0);
    do_commit_check();
    wait_drain();
  endtask

  task automatic do_commit_check();
    vec_t xi, xq;
    w_commit = 1'b1;
    @(posedge clk);
    #1;
    w_commit = 1'b0;
    ac_i = sh_i;
    ac_q = sh_q;
    rand_vec(xi);
    rand_vec(xq);
    xq[1] = -777;
    send(xi, xq, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    x_I = '0;
    x_Q = '0;
    w_we = 1'b0;
    w_addr = '0;
    w_I = '0;
    w_Q = '0;
    w_commit = 1'b0;
    conj_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_conj();
    test_extreme();
    test_back_to_back();
    test_commit_inflight();
    test_reset_midflight();
    repeat (5) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/complex_beamform_mac.md
Name: complex_beamform_mac

Overview:
- Parametrised, pipelined complex weighted sum: y = sum over k of x_k * w_k, or x_k * conj(w_k), across N_CH antenna channels.
- Generalises the fixed 4-channel combinational combiner: adds a clocked pipeline, a valid/ready handshake with backpressure, and runtime-loadable double-buffered steering weights.
- Sits between the channel sample alignment stage and the beam power/detection stage.

Parameters:
- N_CH, 4, number of channels (>=2, power of two).
- WORD_LENGTH, 12, signed width of each I/Q sample and weight component.
- Y_WORD_LENGTH, 2*WORD_LENGTH+1+$clog2(N_CH), output width; exact (lossless) by construction.
- ADDR_W, max(1,$clog2(N_CH)), weight address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  block accepts a sample vector this cycle.
- x_I  in  N_CH*WORD_LENGTH  real parts; channel k at bits [k*W +: W], signed.
- x_Q  in  N_CH*WORD_LENGTH  imaginary parts, same packing.
- w_we  in  1  write to the shadow weight bank.
- w_addr  in  ADDR_W  channel index for the weight write.
- w_I, w_Q  in  WORD_LENGTH  weight value, signed.
- w_commit  in  1  copy the shadow bank to the active bank.
- conj_en  in  1  1: multiply by conj(w); 0: multiply by w. Sampled with each accepted vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y_I, y_Q  out  Y_WORD_LENGTH  signed result.

Behaviour:
- Reset: out_valid=0; y_I=y_Q=0; all pipeline valid bits 0; both weight banks cleared to 0 (output is 0 until weights are loaded).
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stall and in_ready:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every pipeline register, valid bit and conj tag holds.
  - Bubbles are not compressed.
- Pipeline stages (LAT = 3 + $clog2(N_CH) cycles from input transfer to out_valid, no stall):
  - S1: register the 4 real products per channel: xI*wI, xQ*wQ, xI*wQ, xQ*wI, each 2*W bits.
  - S2: per channel:
    - pI = xI*wI - xQ*wQ and pQ = xI*wQ + xQ*wI when conj_en=0.
    - pI = xI*wI + xQ*wQ and pQ = xQ*wI - xI*wQ when conj_en=1.
    - Sign-extend to 2W+1 bits.
  - S3 .. S3+log2(N_CH)-1: registered binary adder tree, growing 1 bit per level.
  - Final level drives y_I/y_Q and out_valid.
- Throughput: one vector per cycle when out_ready=1.
- Arithmetic: full-precision signed, no rounding, no saturation. Extreme case -2^(W-1) on every input and weight must be exact.
- Weights:
  - w_we writes shadow[w_addr] at the edge. An out-of-range w_addr (N_CH not equal to 2^ADDR_W) is ignored.
  - w_commit copies shadow to active at the edge. Accepted vectors always use the active bank.
  - The active bank is read at S1 entry, so a commit never affects vectors already in flight.
  - w_we and w_commit in the same cycle: the write lands in shadow first, and the commit copies the updated value.
  - Weight writes and commits are accepted regardless of stall.
- Reset mid-operation flushes all in-flight vectors. No out_valid for any vector accepted before reset.
- out_valid may not depend combinationally on out_ready. y_I/y_Q must be stable while out_valid && !out_ready.

Decomposition:
- Package beamform_pkg: Y_WORD_LENGTH derivation function, ADDR_W function, a lane-slice helper function for packed buses.
- Sub-module cplx_mul_stage: single-channel S1+S2, parameterised on WORD_LENGTH, with the conj_en tag passed through. Instantiated N_CH times via generate.
- Adder tree and weight banks stay in the top level.

Test Plan:
- Reset, load w_k=(1,0) for all k, commit, send x_k=(k+1, -(k+1)) with conj_en=0 -> after LAT cycles y=(10,-10) for N_CH=4.
- Weights w=(3,4), x=(1,2) on all 4 channels -> conj_en=0 gives y=(-20,40); conj_en=1 gives y=(44,8).
- All inputs and weights = -2048, conj_en=0, N_CH=4 -> y_I=0, y_Q=33554432 exact, with no overflow at Y_WORD_LENGTH=27.
- Stream 20 back-to-back vectors with out_ready low on cycles 5-9 -> in_ready low during the stall, no vector lost or duplicated, outputs in order, y held constant while stalled.
- Shadow write plus commit while 3 vectors are in flight -> in-flight results use the old weights, next accepted vector uses the new ones; write and commit in the same cycle take effect together.
- Assert rst for 1 cycle with the pipeline full -> out_valid=0 and y=0 the following cycle, no stale outputs afterwards, weights read back 0.
